vscale_md_issue: RTL and testbench
==================================

# vscale_md_issue

Pipeline-side initiator for the iterative multiply/divide unit. Accepts one decoded RV32M instruction (funct3 plus two operands) from the execute stage, applies the divide-by-zero fast path, drives the unit's req/resp handshake, and returns one registered writeback result. It also handles pipeline kills, including draining an operation the unit has already accepted.

## Interface
- Parameters: none. Widths come from `XPR_LEN` (32). Op and output-select encodings come from vscale_md_constants.vh: `MD_OP_MUL/DIV/REM` and `MD_OUT_LO/HI/REM`.
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  execute stage presents an M-extension instruction
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_funct3  in  3  RV32M funct3
- cmd_rs1  in  32  operand 1
- cmd_rs2  in  32  operand 2
- kill  in  1  flush the current/offered operation
- busy  out  1  stall request to the pipeline; high in REQ, WAIT, DRAIN
- wb_valid  out  1  one-cycle result pulse
- wb_data  out  32  registered result; held until the next accept
- req_valid  out  1  to the unit; high only in REQ
- req_ready  in  1  from the unit
- req_op  out  `MD_OP_WIDTH`  operation
- req_out_sel  out  `MD_OUT_SEL_WIDTH`  output selector
- req_in_1_signed, req_in_2_signed  out  1 each  operand signedness
- req_in_1, req_in_2  out  32  operands, driven from capture registers
- resp_valid  in  1  single-cycle response pulse from the unit; no backpressure
- resp_result  in  32  unit result

## Operation
- Accept: `cmd_valid && cmd_ready && !kill`. On accept, latch funct3, rs1 and rs2. Unit-side outputs come from these registers and stay stable until the next accept.
- Decode of funct3 to op / out_sel / signed1 / signed2:
  - 000 MUL: MUL / LO / 1 / 1
  - 001 MULH: MUL / HI / 1 / 1
  - 010 MULHSU: MUL / HI / 1 / 0
  - 011 MULHU: MUL / HI / 0 / 0
  - 100 DIV: DIV / LO / 1 / 1
  - 101 DIVU: DIV / LO / 0 / 0
  - 110 REM: REM / REM / 1 / 1
  - 111 REMU: REM / REM / 0 / 0
- Fast path: funct3[2]=1 and rs2==0 bypasses the unit.
  - DIV/DIVU result is 0xFFFFFFFF.
  - REM/REMU result is rs1.
  - wb_data is loaded at accept; go directly to DONE.
- States:
  - IDLE: on accept, go to DONE (fast path) or REQ.
  - REQ: req_valid=1. On req_ready, go to WAIT. With kill: go to IDLE if req_ready=0; go to DRAIN if req_ready=1, because the handshake completes that cycle.
  - WAIT: on resp_valid, latch resp_result into wb_data and go to DONE. With kill: go to DRAIN; if resp_valid is high the same cycle, discard the result and go to IDLE.
  - DONE: wb_valid = !kill; always go to IDLE next. A killed DONE does not change wb_data.
  - DRAIN: discard the next resp_valid and go to IDLE; wb_data unchanged; kill has no effect.
- Accepted operations that are never killed produce exactly one wb_valid each.

## Timing
- Reset values: state=IDLE, cmd_ready=1, busy=0, req_valid=0, wb_valid=0, wb_data=0, all request registers 0.
- Unit path (unit idle, 32 compute cycles): accept at T, req_valid at T+1 (accepted), resp_valid at T+35, wb_valid at T+36.
- Fast path: accept at T, wb_valid at T+1.
- No new accept until back in IDLE; the earliest back-to-back accept is the cycle after DONE.
- A kill in the accept cycle wins: the command is not accepted and state is unchanged.
- Reset mid-operation returns to IDLE immediately. The unit is reset by the same signal, so nothing is drained.
- If the unit is busy (req_ready=0), stay in REQ with req_valid and all request fields held constant.

## Test plan
- MULH with rs1=0xFFFFFFFE, rs2=3 -> req_op=MUL, out_sel=HI, both signed; wb_data=0xFFFFFFFF at T+36, wb_valid high for exactly one cycle.
- DIVU with rs1=100, rs2=0 -> no req_valid ever; wb_data=0xFFFFFFFF and wb_valid at T+1. REM with rs1=0x80000005, rs2=0 -> wb_data=0x80000005.
- REM with rs1=-7, rs2=2 (unit path) -> wb_data=0xFFFFFFFF (-1); busy high from T+1 through T+35.
- DIV 20/3 accepted, kill pulsed in WAIT at T+10 -> state DRAIN, busy stays high, the unit response at T+35 is dropped, no wb_valid, wb_data unchanged, cmd_ready at T+36.
- kill in REQ with req_ready forced low -> return to IDLE with no unit request. kill coincident with cmd_valid in IDLE -> not accepted.
- Reset asserted mid-WAIT -> next cycle all outputs at their reset values. Then MULHSU rs1=-1, rs2=0xFFFFFFFF -> wb_data=0xFFFFFFFF.

Source files
------------

// File: rtl/vscale_md_issue_if.sv
// Shared widths/encodings for the multiply/divide issue path, and the bundle
// connecting the execute stage, the issue block and the iterative unit.
package vscale_md_pkg;
    localparam int unsigned XPR_LEN          = 32;
    localparam int unsigned MD_OP_WIDTH      = 2;
    localparam int unsigned MD_OUT_SEL_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

    // Decoded control half of a unit request.
    typedef struct packed {
        logic [MD_OP_WIDTH-1:0]      op;
        logic [MD_OUT_SEL_WIDTH-1:0] out_sel;
        logic                        in_1_signed;
        logic                        in_2_signed;
    } md_ctrl_t;
endpackage

interface vscale_md_issue_if;
    import vscale_md_pkg::*;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [2:0]                  cmd_funct3;
    logic [XPR_LEN-1:0]          cmd_rs1;
    logic [XPR_LEN-1:0]          cmd_rs2;
    logic                        kill;
    logic                        busy;
    logic                        wb_valid;
    logic [XPR_LEN-1:0]          wb_data;
    logic                        req_valid;
    logic                        req_ready;
    logic [MD_OP_WIDTH-1:0]      req_op;
    logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
    logic                        req_in_1_signed;
    logic                        req_in_2_signed;
    logic [XPR_LEN-1:0]          req_in_1;
    logic [XPR_LEN-1:0]          req_in_2;
    logic                        resp_valid;
    logic [XPR_LEN-1:0]          resp_result;

    // master: the issue block; slave: pipeline plus unit around it.
    modport master (
        input  cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, kill,
               req_ready, resp_valid, resp_result,
        output cmd_ready, busy, wb_valid, wb_data, req_valid, req_op,
               req_out_sel, req_in_1_signed, req_in_2_signed, req_in_1, req_in_2
    );

    modport slave (
        output cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, kill,
               req_ready, resp_valid, resp_result,
        input  cmd_ready, busy, wb_valid, wb_data, req_valid, req_op,
               req_out_sel, req_in_1_signed, req_in_2_signed, req_in_1, req_in_2
    );
endinterface

// File: rtl/vscale_md_issue.sv
// Issues one RV32M instruction to the iterative multiply/divide unit, handles
// the divide-by-zero shortcut and pipeline kills, and returns a registered result.
module vscale_md_issue
    import vscale_md_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    vscale_md_issue_if.master md
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               fast_path;
    logic [XPR_LEN-1:0] fast_result;
    md_ctrl_t           ctrl_dec;
    logic               done_q;

    assign accept      = md.cmd_valid && md.cmd_ready && !md.kill;
    assign fast_path   = md.cmd_funct3[2] && (md.cmd_rs2 == '0);
    // Divide by zero yields all ones; remainder by zero yields the dividend.
    assign fast_result = md.cmd_funct3[1] ? md.cmd_rs1 : '1;

    // funct3 -> unit op, output half and operand signedness
    always_comb begin
        ctrl_dec = '0;
        unique case (md.cmd_funct3)
            3'b000: ctrl_dec = '{MD_OP_MUL, MD_OUT_LO,  1'b1, 1'b1};
            3'b001: ctrl_dec = '{MD_OP_MUL, MD_OUT_HI,  1'b1, 1'b1};
            3'b010: ctrl_dec = '{MD_OP_MUL, MD_OUT_HI,  1'b1, 1'b0};
            3'b011: ctrl_dec = '{MD_OP_MUL, MD_OUT_HI,  1'b0, 1'b0};
            3'b100: ctrl_dec = '{MD_OP_DIV, MD_OUT_LO,  1'b1, 1'b1};
            3'b101: ctrl_dec = '{MD_OP_DIV, MD_OUT_LO,  1'b0, 1'b0};
            3'b110: ctrl_dec = '{MD_OP_REM, MD_OUT_REM, 1'b1, 1'b1};
            default: ctrl_dec = '{MD_OP_REM, MD_OUT_REM, 1'b0, 1'b0};
        endcase
    end

    // A kill that lands on a completed handshake must still drain the response.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_next = fast_path ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (md.kill)           state_next = md.req_ready ? S_DRAIN : S_IDLE;
                else if (md.req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (md.kill)            state_next = md.resp_valid ? S_IDLE : S_DRAIN;
                else if (md.resp_valid) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            S_DRAIN: begin
                if (md.resp_valid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            md.cmd_ready       <= 1'b1;
            md.busy            <= 1'b0;
            md.req_valid       <= 1'b0;
            done_q             <= 1'b0;
            md.wb_data         <= '0;
            md.req_op          <= '0;
            md.req_out_sel     <= '0;
            md.req_in_1_signed <= 1'b0;
            md.req_in_2_signed <= 1'b0;
            md.req_in_1        <= '0;
            md.req_in_2        <= '0;
        end else begin
            state        <= state_next;
            md.cmd_ready <= (state_next == S_IDLE);
            md.busy      <= (state_next == S_REQ) || (state_next == S_WAIT) ||
                            (state_next == S_DRAIN);
            md.req_valid <= (state_next == S_REQ);
            done_q       <= (state_next == S_DONE);

            if (accept) begin
                md.req_op          <= ctrl_dec.op;
                md.req_out_sel     <= ctrl_dec.out_sel;
                md.req_in_1_signed <= ctrl_dec.in_1_signed;
                md.req_in_2_signed <= ctrl_dec.in_2_signed;
                md.req_in_1        <= md.cmd_rs1;
                md.req_in_2        <= md.cmd_rs2;
                if (fast_path) md.wb_data <= fast_result;
            end

            if ((state == S_WAIT) && md.resp_valid && !md.kill) begin
                md.wb_data <= md.resp_result;
            end
        end
    end

    // A kill in the DONE cycle suppresses the writeback pulse directly.
    assign md.wb_valid = done_q && !md.kill;

endmodule

// File: tb/tb_vscale_md_issue.sv
// Directed and randomized bench for vscale_md_issue with a behavioural
// multiply/divide unit and an arithmetic RV32M reference model.
module tb_vscale_md_issue;
    import vscale_md_pkg::*;

    localparam int unsigned UNIT_LAT = 33;

    logic clk;
    logic reset;
    bit   hold_ready;
    int   checks;
    int   errors;
    int   hs_count;
    logic [31:0] last_wb;

    logic        u_busy;
    int          u_cnt;
    logic [31:0] u_res;

    vscale_md_issue_if bus();

    vscale_md_issue dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RV32M semantics written per instruction.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                if (ua < 0) return 32'd0;
                return a % b;
            end
        endcase
    endfunction

    // Expected {op, out_sel, signed1, signed2} for each funct3.
    function automatic logic [5:0] exp_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return {MD_OP_MUL, MD_OUT_LO,  2'b11};
            3'b001:  return {MD_OP_MUL, MD_OUT_HI,  2'b11};
            3'b010:  return {MD_OP_MUL, MD_OUT_HI,  2'b10};
            3'b011:  return {MD_OP_MUL, MD_OUT_HI,  2'b00};
            3'b100:  return {MD_OP_DIV, MD_OUT_LO,  2'b11};
            3'b101:  return {MD_OP_DIV, MD_OUT_LO,  2'b00};
            3'b110:  return {MD_OP_REM, MD_OUT_REM, 2'b11};
            default: return {MD_OP_REM, MD_OUT_REM, 2'b00};
        endcase
    endfunction

    // Unit behaviour: operate on extended operands as the request fields describe.
    function automatic logic [31:0] unit_compute(input logic [1:0] op, input logic [1:0] sel,
                                                 input logic s1, input logic s2,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint      x, y;
        logic [63:0] p;
        if (s1) x = longint'($signed(a)); else x = longint'({32'b0, a});
        if (s2) y = longint'($signed(b)); else y = longint'({32'b0, b});
        if (op == MD_OP_MUL) begin
            p = 64'(x * y);
            return (sel == MD_OUT_HI) ? p[63:32] : p[31:0];
        end else if (op == MD_OP_DIV) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = 64'(x / y);
            return p[31:0];
        end else begin
            if (b == 32'd0) return a;
            p = 64'(x % y);
            return p[31:0];
        end
    endfunction

    assign bus.req_ready = !u_busy && !hold_ready;

    // Iterative unit model: fixed compute latency, one response pulse.
    always @(posedge clk) begin
        if (reset) begin
            u_busy          <= 1'b0;
            u_cnt           <= 0;
            u_res           <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_result <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                u_busy   <= 1'b1;
                u_cnt    <= int'(UNIT_LAT);
                u_res    <= unit_compute(bus.req_op, bus.req_out_sel, bus.req_in_1_signed,
                                         bus.req_in_2_signed, bus.req_in_1, bus.req_in_2);
                hs_count <= hs_count + 1;
            end else if (u_busy) begin
                if (u_cnt == 1) begin
                    bus.resp_valid  <= 1'b1;
                    bus.resp_result <= u_res;
                    u_busy          <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.cmd_valid  = 1'b1;
        bus.cmd_funct3 = f3;
        bus.cmd_rs1    = a;
        bus.cmd_rs2    = b;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    // Runs one un-killed op from IDLE; returns at the negedge after the result pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        bit          fast, seen_req, seen_wb, busy_ok;
        int          lat;
        exp      = ref_result(f3, a, b);
        fast     = f3[2] && (b == 32'd0);
        seen_req = 0;
        seen_wb  = 0;
        busy_ok  = 1;
        lat      = 0;
        issue(f3, a, b);
        for (int n = 1; n <= 200 && !seen_wb; n++) begin
            if (bus.req_valid && !seen_req) begin
                seen_req = 1;
                check({tag, "/ctrl"}, 64'({bus.req_op, bus.req_out_sel, bus.req_in_1_signed,
                                           bus.req_in_2_signed}), 64'(exp_ctrl(f3)));
                check({tag, "/operands"}, {bus.req_in_1, bus.req_in_2}, {a, b});
            end
            if (bus.wb_valid) begin
                seen_wb = 1;
                lat     = n;
            end else begin
                if (!bus.busy) busy_ok = 0;
                @(negedge clk);
            end
        end
        check({tag, "/latency"}, 64'(lat), fast ? 64'd1 : 64'd36);
        check({tag, "/wb_data"}, 64'(bus.wb_data), 64'(exp));
        check({tag, "/unit_used"}, 64'(seen_req), 64'(!fast));
        check({tag, "/busy_while_pending"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        check({tag, "/wb_pulse_end"}, {31'b0, bus.wb_valid, 31'b0, bus.cmd_ready}, {32'd0, 32'd1});
        check({tag, "/wb_hold"}, 64'(bus.wb_data), 64'(exp));
        last_wb = exp;
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        bit          wb_seen, busy_ok;
        logic        rdy35, rdy36;
        int          hs_before;

        checks         = 0;
        errors         = 0;
        hs_count       = 0;
        last_wb        = '0;
        hold_ready     = 0;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_funct3 = '0;
        bus.cmd_rs1    = '0;
        bus.cmd_rs2    = '0;
        bus.kill       = 1'b0;

        // Reset values
        @(negedge clk);
        check("reset/handshake", {60'b0, bus.cmd_ready, bus.busy, bus.req_valid, bus.wb_valid},
              64'b1000);
        check("reset/wb_data", 64'(bus.wb_data), 64'd0);
        check("reset/req_regs", {bus.req_in_1, bus.req_in_2}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed ops from the test plan
        run_op("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3);
        run_op("divu_zero", 3'b101, 32'd100, 32'd0);
        run_op("rem_zero", 3'b110, 32'h8000_0005, 32'd0);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);

        // Kill in WAIT: the response must be drained and dropped
        wb_seen = 0;
        busy_ok = 1;
        rdy35   = 1'b0;
        rdy36   = 1'b0;
        issue(3'b100, 32'd20, 32'd3);
        for (int n = 1; n <= 40; n++) begin
            if (bus.wb_valid) wb_seen = 1;
            if (n <= 35 && !bus.busy) busy_ok = 0;
            if (n == 35) rdy35 = bus.cmd_ready;
            if (n == 36) rdy36 = bus.cmd_ready;
            bus.kill = (n == 10);
            @(negedge clk);
        end
        check("kill_wait/no_wb", 64'(wb_seen), 64'd0);
        check("kill_wait/busy", 64'(busy_ok), 64'd1);
        check("kill_wait/ready_timing", {62'b0, rdy35, rdy36}, 64'b01);
        check("kill_wait/wb_data", 64'(bus.wb_data), 64'(last_wb));

        // Kill in REQ while the unit refuses: no handshake, straight back to IDLE
        hold_ready = 1;
        hs_before  = hs_count;
        issue(3'b000, 32'h1234_5678, 32'h0000_0010);
        for (int n = 1; n <= 3; n++) begin
            check("kill_req/held_valid", {63'b0, bus.req_valid}, 64'd1);
            check("kill_req/held_fields", {26'b0, bus.req_op, bus.req_out_sel,
                  bus.req_in_1_signed, bus.req_in_2_signed, bus.req_in_1},
                  {26'b0, exp_ctrl(3'b000), 32'h1234_5678});
            bus.kill = (n == 3);
            @(negedge clk);
        end
        bus.kill = 1'b0;
        check("kill_req/idle", {61'b0, bus.cmd_ready, bus.busy, bus.req_valid}, 64'b100);
        hold_ready = 0;
        wb_seen    = 0;
        for (int n = 0; n < 6; n++) begin
            if (bus.wb_valid || bus.req_valid) wb_seen = 1;
            @(negedge clk);
        end
        check("kill_req/no_activity", 64'(wb_seen), 64'd0);
        check("kill_req/no_handshake", 64'(hs_count), 64'(hs_before));

        // Kill coincident with cmd_valid: command must not be taken
        bus.cmd_valid  = 1'b1;
        bus.cmd_funct3 = 3'b101;
        bus.cmd_rs1    = 32'hDEAD_BEEF;
        bus.cmd_rs2    = 32'd0;
        bus.kill       = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.kill      = 1'b0;
        check("kill_accept/state", {60'b0, bus.cmd_ready, bus.busy, bus.req_valid, bus.wb_valid},
              64'b1000);
        check("kill_accept/not_latched", 64'(bus.req_in_1), 64'h1234_5678);
        @(negedge clk);
        check("kill_accept/no_wb", {63'b0, bus.wb_valid}, 64'd0);

        // Reset in the middle of WAIT
        issue(3'b100, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid/handshake", {60'b0, bus.cmd_ready, bus.busy, bus.req_valid,
              bus.wb_valid}, 64'b1000);
        check("reset_mid/wb_data", 64'(bus.wb_data), 64'd0);
        check("reset_mid/req_regs", {bus.req_in_1, bus.req_in_2}, 64'd0);
        check("reset_mid/req_ctrl", 64'({bus.req_op, bus.req_out_sel, bus.req_in_1_signed,
              bus.req_in_2_signed}), 64'd0);
        @(negedge clk);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            run_op("random", f3, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
